// File: rtl/layer1_window_ctrl.sv
// Sequencing controller for the layer-1 line buffer: paces the raster pixel
// stream and hands complete 3x3 windows to the MAC array, stalling on back-pressure.
module layer1_window_ctrl #(
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32,
    parameter int CNT_W      = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             shift_en,
    output logic             win_valid,
    input  logic             win_ready,
    output logic [CNT_W-1:0] win_row,
    output logic [CNT_W-1:0] win_col,
    output logic             busy,
    output logic             frame_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_WIDTH - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_HEIGHT - 1);
    localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] row_reg, row_next;
    logic [CNT_W-1:0] col_reg, col_next;
    logic [CNT_W-1:0] win_row_reg, win_row_next;
    logic [CNT_W-1:0] win_col_reg, win_col_next;
    logic             win_valid_reg, win_valid_next;

    logic stall;
    logic accept;
    logic consume;
    logic gen_window;

    // A pending, unconsumed window freezes the stream so the buffer never shifts under it.
    assign stall      = win_valid_reg & ~win_ready;
    assign in_ready   = (state_reg == RUN) & ~stall;
    assign accept     = in_valid & in_ready;
    assign shift_en   = accept;
    assign consume    = win_valid_reg & win_ready;
    assign gen_window = accept & (row_reg >= TWO) & (col_reg >= TWO);

    assign win_valid  = win_valid_reg;
    assign win_row    = win_row_reg;
    assign win_col    = win_col_reg;
    assign busy       = (state_reg != IDLE);
    assign frame_done = (state_reg == DONE);

    always_comb begin
        state_next     = state_reg;
        row_next       = row_reg;
        col_next       = col_reg;
        win_valid_next = win_valid_reg;
        win_row_next   = win_row_reg;
        win_col_next   = win_col_reg;

        case (state_reg)
            IDLE: begin
                row_next = '0;
                col_next = '0;
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    if (col_reg == COL_LAST) begin
                        col_next = '0;
                        if (row_reg == ROW_LAST) begin
                            row_next   = '0;
                            state_next = DRAIN;
                        end else begin
                            row_next = row_reg + 1'b1;
                        end
                    end else begin
                        col_next = col_reg + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (consume) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A new window on the consuming edge replaces the old one without a bubble.
        if (gen_window) begin
            win_valid_next = 1'b1;
            win_row_next   = row_reg - TWO;
            win_col_next   = col_reg - TWO;
        end else if (consume) begin
            win_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            row_reg       <= '0;
            col_reg       <= '0;
            win_valid_reg <= 1'b0;
            win_row_reg   <= '0;
            win_col_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            row_reg       <= row_next;
            col_reg       <= col_next;
            win_valid_reg <= win_valid_next;
            win_row_reg   <= win_row_next;
            win_col_reg   <= win_col_next;
        end
    end

endmodule

// File: tb/tb_layer1_window_ctrl.sv
// Directed bench for layer1_window_ctrl: a 5x5 instance for handshake corner
// cases and a default 32x32 instance for a full-size frame.
module tb_layer1_window_ctrl;

    localparam int SW = 5;
    localparam int SH = 5;
    localparam int BW = 32;
    localparam int BH = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       s_start, s_in_valid, s_win_ready;
    logic       s_in_ready, s_shift_en, s_win_valid, s_busy, s_frame_done;
    logic [5:0] s_win_row, s_win_col;

    logic       b_start, b_in_valid, b_win_ready;
    logic       b_in_ready, b_shift_en, b_win_valid, b_busy, b_frame_done;
    logic [5:0] b_win_row, b_win_col;

    layer1_window_ctrl #(.IMG_WIDTH(SW), .IMG_HEIGHT(SH), .CNT_W(6)) dut_small (
        .clk(clk), .rst(rst), .start(s_start), .in_valid(s_in_valid),
        .in_ready(s_in_ready), .shift_en(s_shift_en), .win_valid(s_win_valid),
        .win_ready(s_win_ready), .win_row(s_win_row), .win_col(s_win_col),
        .busy(s_busy), .frame_done(s_frame_done)
    );

    layer1_window_ctrl dut_big (
        .clk(clk), .rst(rst), .start(b_start), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .shift_en(b_shift_en), .win_valid(b_win_valid),
        .win_ready(b_win_ready), .win_row(b_win_row), .win_col(b_win_col),
        .busy(b_busy), .frame_done(b_frame_done)
    );

    int checks = 0;
    int errors = 0;

    int acc, wins, fdones, cyc, first_wv_acc, last_acc_cyc, fd_cyc, stall_cnt;
    int last_row, last_col;
    logic prev_stall;
    logic [5:0] prev_row, prev_col;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic rd_wv(input bit big);
        return big ? b_win_valid : s_win_valid;
    endfunction

    task automatic drive(input bit big, input logic st, input logic iv, input logic wr);
        s_start = big ? 1'b0 : st;  s_in_valid = big ? 1'b0 : iv;  s_win_ready = big ? 1'b0 : wr;
        b_start = big ? st : 1'b0;  b_in_valid = big ? iv : 1'b0;  b_win_ready = big ? wr : 1'b0;
    endtask

    task automatic clear_stats();
        acc = 0; wins = 0; fdones = 0; cyc = 0; first_wv_acc = -1;
        last_acc_cyc = -100; fd_cyc = -1; stall_cnt = 0; prev_stall = 1'b0;
        last_row = -1; last_col = -1;
    endtask

    task automatic check_reset(input bit big, input string tag);
        check({tag, "_in_ready"},   big ? b_in_ready   : s_in_ready,   0);
        check({tag, "_shift_en"},   big ? b_shift_en   : s_shift_en,   0);
        check({tag, "_win_valid"},  big ? b_win_valid  : s_win_valid,  0);
        check({tag, "_win_row"},    big ? b_win_row    : s_win_row,    0);
        check({tag, "_win_col"},    big ? b_win_col    : s_win_col,    0);
        check({tag, "_busy"},       big ? b_busy       : s_busy,       0);
        check({tag, "_frame_done"}, big ? b_frame_done : s_frame_done, 0);
    endtask

    // Samples one cycle at the falling edge, scores it, then returns 1 time unit after the next rising edge.
    task automatic sample(input bit big);
        logic iv, ir, se, wv, wr, fd;
        logic [5:0] row, col;
        int w;
        @(negedge clk);
        w  = big ? BW : SW;
        iv = big ? b_in_valid   : s_in_valid;
        ir = big ? b_in_ready   : s_in_ready;
        se = big ? b_shift_en   : s_shift_en;
        wv = big ? b_win_valid  : s_win_valid;
        wr = big ? b_win_ready  : s_win_ready;
        fd = big ? b_frame_done : s_frame_done;
        row = big ? b_win_row : s_win_row;
        col = big ? b_win_col : s_win_col;
        check("shift_en", se, iv & ir);
        if (prev_stall) begin
            check("stall_hold_valid", wv, 1);
            check("stall_hold_row", row, prev_row);
            check("stall_hold_col", col, prev_col);
        end
        if (wv && !wr) check("stall_in_ready", ir, 0);
        if (wv && first_wv_acc < 0) first_wv_acc = acc;
        if (wv && wr) begin
            check("win_row", row, wins / (w - 2));
            check("win_col", col, wins % (w - 2));
            last_row = row;
            last_col = col;
            wins++;
        end
        if (se) begin
            acc++;
            last_acc_cyc = cyc;
        end
        if (fd) begin
            fdones++;
            fd_cyc = cyc;
        end
        prev_stall = wv && !wr;
        prev_row = row;
        prev_col = col;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // mode 0: full rate; 1: 3-cycle stall on the first window; 2: in_valid every other cycle;
    // 3: start pulses during RUN, DRAIN and DONE.
    task automatic run_frame(input bit big, input int mode, input string tag);
        int w, h;
        logic st, iv, wr;
        w = big ? BW : SW;
        h = big ? BH : SH;
        clear_stats();
        drive(big, 1'b1, 1'b0, 1'b1);
        check({tag, "_idle_in_ready"}, big ? b_in_ready : s_in_ready, 0);
        sample(big);
        check({tag, "_run_busy"}, big ? b_busy : s_busy, 1);
        check({tag, "_run_first_ready"}, big ? b_in_ready : s_in_ready, 1);
        for (int k = 0; k < 4000 && fdones == 0; k++) begin
            st = 1'b0; iv = 1'b1; wr = 1'b1;
            if (mode == 1 && rd_wv(big) && wins == 0 && stall_cnt < 3) begin
                wr = 1'b0;
                stall_cnt++;
            end
            if (mode == 2) iv = (k % 2 == 0);
            if (mode == 3) st = (acc == 10) || (acc == w * h);
            drive(big, st, iv, wr);
            #1;
            if (!wr) begin
                check({tag, "_stall_ready"}, big ? b_in_ready : s_in_ready, 0);
                check({tag, "_stall_shift"}, big ? b_shift_en : s_shift_en, 0);
                check({tag, "_stall_row"}, big ? b_win_row : s_win_row, 0);
                check({tag, "_stall_col"}, big ? b_win_col : s_win_col, 0);
            end
            sample(big);
        end
        drive(big, 1'b0, 1'b0, 1'b0);
        sample(big);
        sample(big);
        check({tag, "_accepts"}, acc, w * h);
        check({tag, "_windows"}, wins, (w - 2) * (h - 2));
        check({tag, "_frame_done_count"}, fdones, 1);
        check({tag, "_first_win_after_accepts"}, first_wv_acc, 2 * w + 3);
        check({tag, "_done_latency"}, fd_cyc - last_acc_cyc, 2);
        check({tag, "_last_row"}, last_row, h - 3);
        check({tag, "_last_col"}, last_col, w - 3);
        if (mode == 1) check({tag, "_stall_cycles"}, stall_cnt, 3);
        check({tag, "_idle_busy"}, big ? b_busy : s_busy, 0);
        check({tag, "_idle_ready"}, big ? b_in_ready : s_in_ready, 0);
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        #3;
        check_reset(1'b0, "por_small");
        check_reset(1'b1, "por_big");
        @(posedge clk);
        #1;
        rst = 1'b1;

        run_frame(1'b0, 0, "full_rate");
        run_frame(1'b0, 1, "stall3");
        run_frame(1'b0, 2, "toggle_valid");
        run_frame(1'b0, 3, "start_ignored");

        // Abort mid-frame with a window pending.
        clear_stats();
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        sample(1'b0);
        for (int k = 0; k < 200; k++) begin
            if (acc >= 18 && rd_wv(1'b0)) break;
            drive(1'b0, 1'b0, 1'b1, (acc < 17));
            sample(1'b0);
        end
        check("abort_pending_window", s_win_valid, 1);
        check("abort_accepts", acc, 18);
        rst = 1'b0;
        prev_stall = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        check_reset(1'b0, "abort_async");
        sample(1'b0);
        check_reset(1'b0, "abort_next");
        check("abort_no_frame_done", fdones, 0);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        sample(1'b0);
        check("abort_idle_busy", s_busy, 0);
        run_frame(1'b0, 0, "after_abort");

        run_frame(1'b1, 0, "big_full");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
